dbus_responder: RTL and testbench

//  Responder end of the core's data-memory bus (we / byteEnable / a / wd / rd).

---
 rtl/dbus_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dbus_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// dbus_responder: responder end of the core's data-memory bus.
//
// Purpose
//   Drop-in replacement for the data memory beside the core.
//     a[9] = 0 : byte-enabled scratch RAM, word index a[8:2]
//     a[9] = 1 : MMIO
//                0x200 TXDATA  store (lane 0) pushes a byte into the output FIFO
//                0x204 STATUS  {29'b0, overflow, full, empty}; store with wd[2]=1
//                              clears the sticky overflow flag
//                0x208 CYCLE   free-running cycle counter (optional)
//   The output FIFO is drained by an external ready/valid sink.
//
// Configuration
//   DBUS_CYCLE_CNT_EN  when defined, builds the 32-bit CYCLE counter; otherwise
//                      0x208 reads 0 and stores to it are ignored.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   we          in   store strobe
//   byteEnable  in   [3:0] store lane enables, lane i = wd[8i+7:8i]
//   a           in   [9:0] byte address, a[1:0] ignored
//   wd          in   [31:0] store data
//   rd          out  [31:0] load data, combinational from a and current state
//   out_valid   out  FIFO head valid
//   out_data    out  [7:0] FIFO head byte
//   out_ready   in   sink accepts head when out_valid && out_ready

module dbus_responder #(
    parameter int unsigned RAM_WORDS  = 128,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  byteEnable,
    input  logic [9:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int unsigned RamAw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    // MMIO word addresses (a[9:2]).
    localparam logic [7:0] AddrTx     = 8'h80;
    localparam logic [7:0] AddrStatus = 8'h81;
    localparam logic [7:0] AddrCycle  = 8'h82;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [7:0]       word_addr;
    logic [6:0]       word_idx;
    logic [RamAw-1:0] ram_idx;
    logic             ram_in_range;
    logic             unused_addr_lsb;

    assign word_addr       = a[9:2];
    assign word_idx        = a[8:2];
    assign ram_idx         = word_idx[RamAw-1:0];
    assign unused_addr_lsb = ^a[1:0];

    generate
        if (RAM_WORDS >= 128) begin : g_ram_full
            assign ram_in_range = 1'b1;
        end else begin : g_ram_part
            assign ram_in_range = (word_idx < 7'(RAM_WORDS));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scratch RAM (not reset; writes suppressed while reset is asserted)
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];
    logic        ram_we;

    assign ram_we = we && !a[9] && ram_in_range && !reset;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEnable[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic empty, full;
    logic pop, push_req, push, ovf_set, ovf_clr;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CntW'(FIFO_DEPTH));
        pop      = !empty && out_ready;
        push_req = we && byteEnable[0] && (word_addr == AddrTx);
        // A full FIFO still accepts a byte when the head leaves the same cycle.
        push     = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;
        ovf_clr  = we && byteEnable[0] && (word_addr == AddrStatus) && wd[2];

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Set wins over a same-cycle clear.
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_q[wr_ptr_q] <= wd[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset, so the head is masked to 0 while empty.
    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_rd;

`ifdef DBUS_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic        cycle_wr;

    always_comb begin
        cycle_wr = we && (word_addr == AddrCycle) && (byteEnable != 4'b0000);
        cycle_d  = cycle_q + 32'd1;
        if (cycle_wr) begin
            // Store replaces the increment; disabled lanes hold their value.
            for (int i = 0; i < 4; i++) begin
                cycle_d[8*i +: 8] = byteEnable[i] ? wd[8*i +: 8] : cycle_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    always_comb begin
        rd = 32'h0000_0000;
        if (!a[9]) begin
            if (ram_in_range) begin
                rd = ram_q[ram_idx];
            end
        end else begin
            case (word_addr)
                AddrStatus: rd = {29'b0, ovf_q, full, empty};
                AddrCycle:  rd = cycle_rd;
                default:    rd = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
`timescale 1ns/1ps

module tb_dbus_responder;

    localparam int FD = 4;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  byteEnable;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ram_m [128];
    logic [7:0]  q_m [$];
    logic        ovf_m;
    logic [31:0] cyc_m;
    bit          model_ok = 0;

    dbus_responder #(.RAM_WORDS(128), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .byteEnable (byteEnable),
        .a          (a),
        .wd         (wd),
        .rd         (rd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [9:0] addr);
        if (!addr[9]) return ram_m[addr[8:2]];
        case (addr[9:2])
            8'h81: return {29'b0, ovf_m, (q_m.size() == FD), (q_m.size() == 0)};
`ifdef DBUS_CYCLE_CNT_EN
            8'h82: return cyc_m;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock: drive, check outputs against the model before the edge, advance model.
    task automatic step(input logic w, input logic [3:0] be, input logic [9:0] addr,
                        input logic [31:0] d, input logic rdy, input logic rst,
                        input logic chk_rd);
        bit pop;
        int size_before;
        we = w; byteEnable = be; a = addr; wd = d; out_ready = rdy; reset = rst;
        #4;
        if (model_ok) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q_m.size() != 0});
            chk("out_data", {24'b0, out_data}, (q_m.size() != 0) ? {24'b0, q_m[0]} : 32'h0);
            if (chk_rd) chk("rd", rd, exp_rd(addr));
        end
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = 32'h0;
            model_ok = 1;
        end else begin
            if (w && !addr[9]) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ram_m[addr[8:2]][8*i +: 8] = d[8*i +: 8];
            end
            size_before = q_m.size();
            pop = (size_before != 0) && rdy;
            if (pop) void'(q_m.pop_front());
            if (w && be[0] && addr[9:2] == 8'h80) begin
                if (size_before < FD || pop) q_m.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end else if (w && be[0] && addr[9:2] == 8'h81 && d[2]) begin
                ovf_m = 1'b0;
            end
            if (w && addr[9:2] == 8'h82 && be != 4'b0) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) cyc_m[8*i +: 8] = d[8*i +: 8];
            end else begin
                cyc_m = cyc_m + 32'd1;
            end
        end
        #1;
    endtask

    // Combinational load between clock edges (at most two in a row).
    task automatic peek(input string tag, input logic [9:0] addr, input logic [31:0] expv);
        we = 1'b0; a = addr;
        #1;
        chk(tag, rd, expv);
    endtask

    logic [31:0] c0, c1, c2;
    logic [7:0]  drain4 [4];

    initial begin
        reset = 1'b1; we = 1'b0; byteEnable = 4'b0; a = 10'h0; wd = 32'h0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        step(1'b0, 4'b0, 10'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_data", {24'b0, out_data}, 32'h0);
        peek("rst_status", 10'h204, 32'h1);
        peek("rst_cycle", 10'h208, 32'h0);

        // Byte-enabled RAM store
        step(1'b1, 4'b1111, 10'h010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 10'h010, 32'h00AA0000, 1'b0, 1'b0, 1'b0);
        peek("ram_lane", 10'h010, 32'hDEAABEEF);
        step(1'b1, 4'b0000, 10'h010, 32'h12345678, 1'b0, 1'b0, 1'b0);
        peek("ram_be0", 10'h010, 32'hDEAABEEF);
        step(1'b1, 4'b1111, 10'h20C, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        peek("mmio_other", 10'h20C, 32'h0);
        peek("txdata_rd", 10'h200, 32'h0);

        // Fill, then overflow
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'b0001, 10'h200, 32'h41 + i, 1'b0, 1'b0, 1'b0);
        peek("full_status", 10'h204, 32'h2);
        step(1'b1, 4'b0001, 10'h200, 32'h45, 1'b0, 1'b0, 1'b1);
        peek("ovf_status", 10'h204, 32'h6);
        chk("ovf_head", {24'b0, out_data}, 32'h41);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", {24'b0, out_data}, 32'h41 + i);
            step(1'b0, 4'b0, 10'h204, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        chk("drain_valid", {31'b0, out_valid}, 32'h0);
        peek("drain_status", 10'h204, 32'h5);
        step(1'b1, 4'b0001, 10'h204, 32'h4, 1'b0, 1'b0, 1'b0);
        peek("clr_status", 10'h204, 32'h1);

        // Push into a full FIFO while it pops
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'b0001, 10'h200, 32'h11 + i, 1'b0, 1'b0, 1'b0);
        chk("pp_head", {24'b0, out_data}, 32'h11);
        step(1'b1, 4'b0001, 10'h200, 32'h55, 1'b1, 1'b0, 1'b0);
        peek("pp_status", 10'h204, 32'h2);
        drain4[0] = 8'h12; drain4[1] = 8'h13; drain4[2] = 8'h14; drain4[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", {24'b0, out_data}, {24'b0, drain4[i]});
            step(1'b0, 4'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("pp_empty", {31'b0, out_valid}, 32'h0);

        // Reset mid-drain, with a competing push
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'b0001, 10'h200, 32'h61 + i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 10'h200, 32'h99, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_data", {24'b0, out_data}, 32'h0);
        peek("mid_rst_status", 10'h204, 32'h1);
        peek("mid_rst_300", 10'h300, 32'h0);

        // Cycle counter wrap
`ifdef DBUS_CYCLE_CNT_EN
        c0 = 32'hFFFFFFFE; c1 = 32'hFFFFFFFF; c2 = 32'h0;
`else
        c0 = 32'h0; c1 = 32'h0; c2 = 32'h0;
`endif
        step(1'b1, 4'b1111, 10'h208, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        peek("cyc0", 10'h208, c0);
        step(1'b0, 4'b0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        peek("cyc1", 10'h208, c1);
        step(1'b0, 4'b0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        peek("cyc2", 10'h208, c2);

        // Randomised traffic against the model
        for (int w = 0; w < 16; w++)
            step(1'b1, 4'b1111, {1'b0, 7'(w), 2'b00}, $urandom, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            logic [9:0]  ra;
            logic [3:0]  rbe;
            logic [31:0] rdat;
            logic        rw, rrdy, rrst;
            rbe  = 4'($urandom);
            rdat = $urandom;
            rrdy = ($urandom_range(0, 2) != 0);
            rrst = ($urandom_range(0, 79) == 0);
            rw   = 1'b1;
            case ($urandom_range(0, 5))
                0: ra = {1'b0, 7'($urandom_range(0, 15)), 2'($urandom)};
                1: begin ra = {1'b0, 7'($urandom_range(0, 15)), 2'($urandom)}; rw = 1'b0; end
                2: begin ra = {8'h80, 2'($urandom)}; rbe[0] = ($urandom_range(0, 3) != 0); end
                3: ra = {8'h81, 2'($urandom)};
                4: begin ra = {6'b100000, 2'($urandom), 2'($urandom)}; rw = 1'($urandom); end
                default: begin ra = {1'b1, 9'($urandom)}; rw = 1'($urandom); end
            endcase
            step(rw, rbe, ra, rdat, rrdy, rrst, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
